// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues word fetches over req/ack,
// buffers returned words in a small prefetch queue and hands them to decode.
module instr_fetch_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned MEM_LAST = 1500
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fault
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_RST     = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LAST_START = ADDR_W'(MEM_LAST - 3);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_FAULT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              discard_q, discard_d;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];

    logic pc_legal, queue_full, req, push, pop;

    assign pc_legal   = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q <= LAST_START);
    assign queue_full = (count_q == CNT_W'(DEPTH));
    assign pop        = out_valid && out_ready;

    // A request in the redirect cycle would target the stale PC, so it is held off.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        req        = 1'b0;
        push       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!pc_legal) begin
                    state_d = S_FAULT;
                end else if (!queue_full && !redirect_valid) begin
                    req = 1'b1;
                    if (mem_ack) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                    end else begin
                        req_addr_d = fetch_pc_q;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (mem_ack) begin
                    state_d = S_FETCH;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = req_addr_q + ADDR_W'(4);
                    end
                end
            end
            default: ;
        endcase
        if (redirect_valid) begin
            push       = 1'b0;
            fetch_pc_d = redirect_pc;
            if (state_q == S_WAIT && !mem_ack) begin
                discard_d = 1'b1;
            end else begin
                state_d   = S_FETCH;
                discard_d = 1'b0;
            end
        end
    end

    // The FETCH state requests combinationally, so the request is masked while in reset.
    assign mem_req   = req && rst_n;
    assign mem_addr  = (state_q == S_WAIT) ? req_addr_q : fetch_pc_q;
    assign fault     = (state_q == S_FAULT);
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= PC_RST;
            req_addr_q <= PC_RST;
            discard_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // NOTE: queue storage is not reset; outputs are masked by out_valid so stale entries never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= mem_rdata;
            pc_mem[wr_ptr_q]    <= mem_addr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: memory model with programmable ack latency
// and a PC-stream reference model (expected next PC, reset on redirect).
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wait_cnt;

    instr_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // Memory model: acknowledges once a request has been held for 'lat' cycles.
    assign mem_ack   = mem_req && (wait_cnt >= lat);
    assign mem_rdata = word_of(mem_addr);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (!mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0; lat = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_cycle1_valid got %b exp 0", out_valid); end
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== word_of(32'(4 * i))) begin
                errors++; $display("FAIL stream_pop%0d got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h", i, out_valid, out_pc, out_instr, 4 * i, word_of(32'(4 * i)));
            end
            checks++; if (mem_addr !== 32'(4 * (i + 1))) begin errors++; $display("FAIL stream_addr%0d got %h exp %h", i, mem_addr, 4 * (i + 1)); end
        end
    endtask

    task automatic test_backpressure();
        int pushes = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #1; if (mem_req && mem_ack) pushes++;
            tick();
        end
        #1;
        checks++; if (pushes != 4) begin errors++; $display("FAIL bp_pushes got %0d exp 4", pushes); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_when_full got %b exp 0", mem_req); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== word_of(32'(4 * i))) begin
                errors++; $display("FAIL bp_drain%0d got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, 4 * i);
            end
            tick();
        end
    endtask

    task automatic test_redirect_wait();
        bit seen = 1'b0;
        do_reset();
        out_ready = 1'b1; lat = 3;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rw_c1 got req=%b addr=%h exp 1/0", mem_req, mem_addr); end
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h20; #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rw_c2 got req=%b addr=%h exp 1/0", mem_req, mem_addr); end
        tick(); redirect_valid = 1'b0; #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rw_c3 got req=%b addr=%h exp 1/0", mem_req, mem_addr); end
        tick(); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_ack !== 1'b1) begin errors++; $display("FAIL rw_c4_ack got req=%b addr=%h ack=%b exp 1/0/1", mem_req, mem_addr, mem_ack); end
        tick(); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL rw_new_req got req=%b addr=%h exp 1/20", mem_req, mem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_visible got %b exp 0", out_valid); end
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(); #1;
            if (out_valid) begin
                seen = 1'b1;
                checks++; if (out_pc !== 32'h20 || out_instr !== word_of(32'h20)) begin errors++; $display("FAIL rw_first_pc got %h exp 20", out_pc); end
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL rw_timeout got no out_valid exp out_pc=20"); end
    endtask

    task automatic test_redirect_ack_pop();
        bit seen = 1'b0;
        do_reset();
        lat = 1;
        repeat (5) tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || mem_ack !== 1'b1) begin errors++; $display("FAIL rap_setup got req=%b addr=%h ack=%b exp 1/8/1", mem_req, mem_addr, mem_ack); end
        redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1; #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL rap_head got v=%b pc=%h exp 1/0", out_valid, out_pc); end
        tick(); redirect_valid = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rap_flush got %b exp 0", out_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL rap_new_req got req=%b addr=%h exp 1/100", mem_req, mem_addr); end
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(); #1;
            if (out_valid) begin
                seen = 1'b1;
                checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL rap_first_pc got %h exp 100", out_pc); end
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL rap_timeout got no out_valid exp out_pc=100"); end
    endtask

    task automatic test_fault();
        do_reset();
        out_ready = 1'b1;
        repeat (2) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick(); redirect_valid = 1'b0; #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flt_no_req got %b exp 0", mem_req); end
        tick(); #1;
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL flt_set got %b exp 1", fault); end
        repeat (3) tick();
        #1;
        checks++; if (fault !== 1'b1 || mem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flt_sticky got f=%b req=%b v=%b exp 1/0/0", fault, mem_req, out_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h24;
        tick(); redirect_valid = 1'b0; #1;
        checks++; if (fault !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h24) begin errors++; $display("FAIL flt_clear got f=%b req=%b addr=%h exp 0/1/24", fault, mem_req, mem_addr); end
        tick(); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h24) begin errors++; $display("FAIL flt_resume got v=%b pc=%h exp 1/24", out_valid, out_pc); end
    endtask

    task automatic test_mem_end();
        bit req1500 = 1'b0;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'd1488;
        tick(); redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1; if (mem_req && mem_addr == 32'd1500) req1500 = 1'b1;
            tick();
        end
        #1;
        checks++; if (req1500) begin errors++; $display("FAIL end_req1500 got request exp none"); end
        checks++; if (fault !== 1'b1 || mem_req !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL end_fault got f=%b req=%b v=%b exp 1/0/1", fault, mem_req, out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(1488 + 4 * i) || out_instr !== word_of(32'(1488 + 4 * i))) begin
                errors++; $display("FAIL end_drain%0d got v=%b pc=%0d exp v=1 pc=%0d", i, out_valid, out_pc, 1488 + 4 * i);
            end
            tick();
        end
        #1;
        checks++; if (out_valid !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL end_empty got v=%b f=%b exp 0/1", out_valid, fault); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick(); redirect_valid = 1'b0;
        repeat (3) tick();
        lat = 5;
        repeat (2) tick();
        #1;
        checks++; if (mem_req !== 1'b1 || out_valid !== 1'b1 || mem_ack !== 1'b0) begin errors++; $display("FAIL rmw_setup got req=%b v=%b ack=%b exp 1/1/0", mem_req, out_valid, mem_ack); end
        rst_n = 1'b0; #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || fault !== 1'b0) begin
            errors++; $display("FAIL rmw_reset got req=%b addr=%h v=%b ins=%h pc=%h f=%b exp all zero", mem_req, mem_addr, out_valid, out_instr, out_pc, fault);
        end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] prev_addr = 32'h0;
        logic        prev_stall = 1'b0;
        int          pops = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            lat = int'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc = 32'($urandom_range(0, 350)) * 32'd4;
            #1;
            if (prev_stall) begin
                checks++; if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin errors++; $display("FAIL rnd_hold c%0d got req=%b addr=%h exp 1/%h", c, mem_req, mem_addr, prev_addr); end
            end
            if (out_valid && out_ready && !redirect_valid) begin
                checks++;
                if (out_pc !== exp_pc || out_instr !== word_of(exp_pc)) begin
                    errors++; $display("FAIL rnd_pop c%0d got pc=%h ins=%h exp pc=%h ins=%h", c, out_pc, out_instr, exp_pc, word_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            prev_stall = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            tick();
        end
        redirect_valid = 1'b0;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rnd_fault got %b exp 0", fault); end
        checks++; if (pops < 100) begin errors++; $display("FAIL rnd_progress got %0d pops exp >=100", pops); end
    endtask

    initial begin
        redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_fault();
        test_mem_end();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
